// File: rtl/ub_dma_engine.sv
// ub_dma_engine: moves word bursts between valid/ready streams and the
// UnifiedBuffer DMA port, one command at a time.
// Ports: clk/reset (sync, active-high); cmd_* command handshake with
//   direction, start address and length; s_* write-source stream;
//   m_* read-sink stream; dma_* registered UB access port plus
//   dma_data_out read data (1-cycle latency); busy/done status.
module ub_dma_engine #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 10,
  parameter int LEN_W      = 11,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_dir,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              dma_write_en,
  output logic              dma_read_en,
  output logic [ADDR_W-1:0] dma_addr,
  output logic [DATA_W-1:0] dma_data_in,
  input  logic [DATA_W-1:0] dma_data_out,
  output logic              busy,
  output logic              done
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH =
    (CNT_W+1)'(FIFO_DEPTH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WRITE = 2'd1;
  localparam logic [1:0] READ  = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  logic [1:0]        state;
  logic [ADDR_W-1:0] addr;
  logic [LEN_W-1:0]  len;
  logic [LEN_W-1:0]  issued;
  logic              rd_d1;

  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W:0]    occ;

  logic cmd_fire;
  logic more;
  logic last;
  logic wr_fire;
  logic rd_fire;
  logic push;
  logic pop;
  logic drain_end;

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign cmd_fire  = cmd_valid && cmd_ready;

  assign more = (issued < len);
  assign last = ((issued + LEN_W'(1)) == len);

  assign s_ready = (state == WRITE) && more;
  assign wr_fire = s_valid && s_ready;

  // Reads still in the UB pipe (on the port now, or returning data
  // now) already own a FIFO slot, so a new read is only issued when
  // every outstanding word is guaranteed room.
  assign occ = {1'b0, fifo_count}
             + (CNT_W+1)'(dma_read_en)
             + (CNT_W+1)'(rd_d1);

  assign rd_fire = (state == READ) && more
                && (occ < DEPTH);

  assign push    = rd_d1;
  assign m_valid = (fifo_count != '0);
  assign pop     = m_valid && m_ready;
  assign m_data  = m_valid ? fifo_mem[rd_ptr] : '0;

  assign drain_end = (state == DRAIN) && pop
                  && (fifo_count == CNT_W'(1))
                  && !dma_read_en && !rd_d1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      addr         <= '0;
      len          <= '0;
      issued       <= '0;
      rd_d1        <= 1'b0;
      dma_write_en <= 1'b0;
      dma_read_en  <= 1'b0;
      dma_addr     <= '0;
      dma_data_in  <= '0;
      done         <= 1'b0;
    end else begin
      done         <= 1'b0;
      dma_write_en <= 1'b0;
      dma_read_en  <= 1'b0;
      rd_d1        <= dma_read_en;
      unique case (1'b1)
        cmd_fire: begin
          addr   <= cmd_addr;
          len    <= cmd_len;
          issued <= '0;
          if (cmd_len == '0)
            done  <= 1'b1;
          else if (cmd_dir)
            state <= READ;
          else
            state <= WRITE;
        end
        wr_fire: begin
          dma_write_en <= 1'b1;
          dma_addr     <= addr;
          dma_data_in  <= s_data;
          addr         <= addr + ADDR_W'(1);
          issued       <= issued + LEN_W'(1);
          if (last) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        rd_fire: begin
          dma_read_en <= 1'b1;
          dma_addr    <= addr;
          addr        <= addr + ADDR_W'(1);
          issued      <= issued + LEN_W'(1);
          if (last)
            state <= DRAIN;
        end
        drain_end: begin
          state <= IDLE;
          done  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)
        rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      fifo_mem[wr_ptr] <= dma_data_out;
  end

endmodule
